// File: rtl/lut_pkg.sv
// Shared types and sizing helpers for the programmable truth-table evaluator.
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } lut_state_e;

  localparam int unsigned N_MIN = 1;
  localparam int unsigned N_MAX = 8;

  function automatic int unsigned lut_depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic int unsigned lut_cnt_w(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/lut_sweep_eval_if.sv
// Load / evaluate / sweep bus between a driver and lut_sweep_eval.
interface lut_sweep_eval_if #(
  parameter int unsigned N = 4
);

  localparam int unsigned DEPTH = lut_pkg::lut_depth(N);
  localparam int unsigned CW    = lut_pkg::lut_cnt_w(N);

  logic             tt_we;
  logic [DEPTH-1:0] tt_in;
  logic [N-1:0]     x;
  logic             f;
  logic             start;
  logic             busy;
  logic             done;
  logic [CW-1:0]    ones_count;
  logic [N-1:0]     first_one;
  logic             found;

  modport master (
    output tt_we, tt_in, x, start,
    input  f, busy, done, ones_count, first_one, found
  );

  modport slave (
    input  tt_we, tt_in, x, start,
    output f, busy, done, ones_count, first_one, found
  );

endinterface

// File: rtl/lut_sweep_ctrl.sv
// Sweep sequencer: IDLE/SWEEP/DONE FSM, minterm index, handshake and load gating.
module lut_sweep_ctrl
  import lut_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         tt_we_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         tt_load_o,
  output logic         clear_o,
  output logic         step_o,
  output logic [N-1:0] idx_o
);

  lut_state_e   state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic         last_idx;

  assign last_idx = (idx_q == '1);
  assign idx_o    = idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SWEEP;
      SWEEP:   if (last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == SWEEP);
    done_o    = (state_q == DONE);
    tt_load_o = (state_q == IDLE) && tt_we_i;
    clear_o   = (state_q == IDLE) && start_i;
    step_o    = (state_q == SWEEP);
  end

  // Index wraps to zero naturally after the last minterm.
  always_comb begin
    idx_d = idx_q;
    if (clear_o) begin
      idx_d = '0;
    end else if (step_o) begin
      idx_d = idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/lut_sweep_eval.sv
// N-input Boolean function unit: loadable truth table, registered evaluation and exhaustive ON-set sweep.
module lut_sweep_eval
  import lut_pkg::*;
#(
  parameter int unsigned             N       = 4,
  parameter logic [lut_depth(N)-1:0] TT_INIT = '0
) (
  input logic              clk,
  input logic              rst,
  lut_sweep_eval_if.slave  bus
);

  localparam int unsigned DEPTH = lut_depth(N);
  localparam int unsigned CW    = lut_cnt_w(N);

  logic [DEPTH-1:0] tt_q, tt_d;
  logic             f_q, f_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic [N-1:0]     first_q, first_d;
  logic             found_q, found_d;

  logic         tt_load;
  logic         clear;
  logic         step;
  logic [N-1:0] idx;

  lut_sweep_ctrl #(
    .N (N)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start_i   (bus.start),
    .tt_we_i   (bus.tt_we),
    .busy_o    (bus.busy),
    .done_o    (bus.done),
    .tt_load_o (tt_load),
    .clear_o   (clear),
    .step_o    (step),
    .idx_o     (idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q    <= TT_INIT;
      f_q     <= 1'b0;
      ones_q  <= '0;
      first_q <= '0;
      found_q <= 1'b0;
    end else begin
      tt_q    <= tt_d;
      f_q     <= f_d;
      ones_q  <= ones_d;
      first_q <= first_d;
      found_q <= found_d;
    end
  end

  // Evaluation reads the pre-load table so a same-cycle load does not leak into f.
  always_comb begin
    tt_d = tt_q;
    f_d  = tt_q[bus.x];
    if (tt_load) begin
      tt_d = bus.tt_in;
    end
  end

  always_comb begin
    ones_d  = ones_q;
    first_d = first_q;
    found_d = found_q;
    if (clear) begin
      ones_d  = '0;
      first_d = '0;
      found_d = 1'b0;
    end else if (step && tt_q[idx]) begin
      ones_d = ones_q + 1'b1;
      if (!found_q) begin
        first_d = idx;
        found_d = 1'b1;
      end
    end
  end

  assign bus.f          = f_q;
  assign bus.ones_count = ones_q;
  assign bus.first_one  = first_q;
  assign bus.found      = found_q;

endmodule
